alu_seq: RTL and testbench

//  Parametrised, handshaked successor to the 8-bit combinational ALU. Accepts one

---
 rtl/alu_seq.sv | 241 ++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq -- handshaked, parametrised ALU sitting between the datapath register
// file (AC, R) and the accumulator write-back. One operation is in flight at a
// time: it is accepted on a valid/ready input port, and its result and flags are
// held on a valid/ready output port until the consumer takes them.
//
// Optional feature macro: ALU_SEQ_MUL_EN
//   defined     : opcode D is an iterative unsigned shift-add multiply that takes
//                 WIDTH cycles in BUSY and returns the full 2*WIDTH product.
//   not defined : opcode D behaves as PASS (single cycle, C=V=0, result_hi=0).
//
// Parameters
//   WIDTH    operand/result width (>= 4)
//   FLAG_REG 1: Z/N stored in flops with the result; 0: Z/N decoded from a stored
//            flag-source register
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   opcode/AC/R valid
//   in_ready   out  operation can be accepted this cycle
//   opcode     in   4-bit operation select
//   AC, R      in   operands (captured at accept)
//   out_valid  out  result/result_hi/flags valid
//   out_ready  in   consumer takes the result this cycle
//   result     out  operation result (low half of the product for MUL)
//   result_hi  out  upper half of the product for MUL, else 0
//   flags      out  {Z,N,C,V}
module alu_seq #(
   parameter int WIDTH    = 8,
   parameter bit FLAG_REG = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] AC,
   input  logic [WIDTH-1:0] R,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic [3:0]       flags
);

   localparam int MSB   = WIDTH - 1;
   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   // src is the value Z/N are taken from; it differs from res only for CMP,
   // which reports the flags of the subtraction but returns AC unchanged.
   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic [WIDTH-1:0] src;
      logic             c;
      logic             v;
   } alu_t;

   function automatic alu_t alu_op(input logic [3:0]       op,
                                   input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
      alu_t             r;
      logic [WIDTH:0]   wide;
      r.res = a;
      r.src = a;
      r.c   = 1'b0;
      r.v   = 1'b0;
      // Extended difference: top bit is the borrow (a < b unsigned).
      wide  = {1'b0, a} - {1'b0, b};
      case (op)
         4'h0: begin
            wide  = {1'b0, a} + {1'b0, b};
            r.res = wide[MSB:0];
            r.c   = wide[WIDTH];
            r.v   = (a[MSB] == b[MSB]) && (r.res[MSB] != a[MSB]);
         end
         4'h1, 4'hE: begin
            r.res = (op == 4'hE) ? a : wide[MSB:0];
            r.c   = wide[WIDTH];
            r.v   = (a[MSB] != b[MSB]) && (wide[MSB] != a[MSB]);
         end
         4'h2: begin
            wide  = {1'b0, a} + (WIDTH + 1)'(1);
            r.res = wide[MSB:0];
            r.c   = wide[WIDTH];
            r.v   = !a[MSB] && r.res[MSB];
         end
         4'h3: r.res = '0;
         4'h4: r.res = a & b;
         4'h5: r.res = a | b;
         4'h6: r.res = a ^ b;
         4'h7: r.res = ~a;
         4'h8: begin r.res = {a[MSB-1:0], 1'b0};   r.c = a[MSB]; end
         4'h9: begin r.res = {1'b0, a[MSB:1]};     r.c = a[0];   end
         4'hA: begin r.res = {a[MSB], a[MSB:1]};   r.c = a[0];   end
         4'hB: begin r.res = {a[MSB-1:0], a[MSB]}; r.c = a[MSB]; end
         4'hC: begin r.res = {a[0], a[MSB:1]};     r.c = a[0];   end
         default: ;  // D (when handled as PASS) and F: pass AC
      endcase
      r.src = (op == 4'hE) ? wide[MSB:0] : r.res;
      return r;
   endfunction

   state_t           state_q;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] result_hi_q;
   logic             c_q;
   logic             v_q;

   logic             accept;
   logic             load_en;
   alu_t             alu_d;
   logic [WIDTH-1:0] result_d;
   logic [WIDTH-1:0] result_hi_d;
   logic [WIDTH-1:0] src_d;
   logic             c_d;
   logic             v_d;

`ifdef ALU_SEQ_MUL_EN
   logic             is_mul;
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] mplier_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH:0]   sum_d;
   logic [WIDTH-1:0] acc_d;
   logic [WIDTH-1:0] mplier_d;
   logic             mul_last;
`endif

   always_comb begin
      in_ready    = (state_q == IDLE) || ((state_q == DONE) && out_ready);
      accept      = in_valid && in_ready;
      alu_d       = alu_op(opcode, AC, R);
      result_d    = alu_d.res;
      result_hi_d = '0;
      src_d       = alu_d.src;
      c_d         = alu_d.c;
      v_d         = alu_d.v;
`ifdef ALU_SEQ_MUL_EN
      is_mul   = (opcode == 4'hD);
      // {acc,mplier} shifts right one bit per cycle; the multiplier's low bit
      // selects whether the multiplicand is added into the upper half first.
      sum_d    = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
      acc_d    = sum_d[WIDTH:1];
      mplier_d = {sum_d[0], mplier_q[MSB:1]};
      mul_last = (cnt_q == CNT_W'(WIDTH - 1));
      load_en  = (accept && !is_mul) || ((state_q == BUSY) && mul_last);
      if (state_q == BUSY) begin
         result_d    = mplier_d;
         result_hi_d = acc_d;
         src_d       = mplier_d;
         c_d         = |acc_d;
         v_d         = |acc_d;
      end
`else
      load_en = accept;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         result_q    <= '0;
         result_hi_q <= '0;
         c_q         <= 1'b0;
         v_q         <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         mcand_q     <= '0;
         acc_q       <= '0;
         mplier_q    <= '0;
         cnt_q       <= '0;
`endif
      end else begin
         if (load_en) begin
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            c_q         <= c_d;
            v_q         <= v_d;
         end
         case (state_q)
            IDLE, DONE: begin
               if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                  if (is_mul) begin
                     state_q  <= BUSY;
                     mcand_q  <= AC;
                     mplier_q <= R;
                     acc_q    <= '0;
                     cnt_q    <= '0;
                  end else
`endif
                  state_q <= DONE;
               end else if ((state_q == DONE) && out_ready) begin
                  state_q <= IDLE;
               end
            end
`ifdef ALU_SEQ_MUL_EN
            BUSY: begin
               acc_q    <= acc_d;
               mplier_q <= mplier_d;
               cnt_q    <= cnt_q + CNT_W'(1);
               if (mul_last) state_q <= DONE;
            end
`endif
            default: state_q <= IDLE;
         endcase
      end
   end

   generate
      if (FLAG_REG) begin : g_flag_reg
         logic z_q;
         logic n_q;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               z_q <= 1'b0;
               n_q <= 1'b0;
            end else if (load_en) begin
               z_q <= (src_d == '0);
               n_q <= src_d[MSB];
            end
         end
         assign flags = {z_q, n_q, c_q, v_q};
      end else begin : g_flag_comb
         logic [WIDTH-1:0] src_q;
         // Reset to a non-zero, non-negative value so Z and N read 0 after reset.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)     src_q <= WIDTH'(1);
            else if (load_en) src_q <= src_d;
         end
         assign flags = {(src_q == '0), src_q[MSB], c_q, v_q};
      end
   endgenerate

   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign result_hi = result_hi_q;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=8). Expected values come from an arithmetic
// reference model of the operation table; stimulus is mostly $urandom.
module tb_alu_seq;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] opcode;
   logic [7:0] AC;
   logic [7:0] R;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic [7:0] result_hi;
   logic [3:0] flags;

   int total = 0;
   int bad   = 0;

   alu_seq #(.WIDTH(8), .FLAG_REG(1'b1)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .AC        (AC),
      .R         (R),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .result_hi (result_hi),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   // Reference model: plain integer arithmetic on the operation table.
   function automatic void model_op(input logic [3:0] op, input int a, input int b,
                                    output int res, output int hi,
                                    output logic [3:0] flg, output int lat);
      int   sa, sb, s, src;
      logic c, v;
      sa  = (a >= 128) ? a - 256 : a;
      sb  = (b >= 128) ? b - 256 : b;
      res = a; hi = 0; c = 1'b0; v = 1'b0; lat = 1; src = -1; s = 0;
      case (op)
         4'h0: begin s = a + b; res = s % 256; c = (s > 255);
                     v = (sa + sb > 127) || (sa + sb < -128); end
         4'h1: begin res = (a - b + 256) % 256; c = (a < b);
                     v = (sa - sb > 127) || (sa - sb < -128); end
         4'h2: begin s = a + 1; res = s % 256; c = (s > 255); v = (sa + 1 > 127); end
         4'h3: res = 0;
         4'h4: res = a & b;
         4'h5: res = a | b;
         4'h6: res = a ^ b;
         4'h7: res = 255 - a;
         4'h8: begin res = (a * 2) % 256; c = (a >= 128); end
         4'h9: begin res = a / 2; c = (a % 2 == 1); end
         4'hA: begin res = a / 2 + ((a >= 128) ? 128 : 0); c = (a % 2 == 1); end
         4'hB: begin res = (a * 2) % 256 + a / 128; c = (a >= 128); end
         4'hC: begin res = a / 2 + (a % 2) * 128; c = (a % 2 == 1); end
`ifdef ALU_SEQ_MUL_EN
         4'hD: begin s = a * b; res = s % 256; hi = s / 256; c = (hi != 0); v = c; lat = 9; end
`else
         4'hD: res = a;
`endif
         4'hE: begin res = a; src = (a - b + 256) % 256; c = (a < b);
                     v = (sa - sb > 127) || (sa - sb < -128); end
         default: res = a;
      endcase
      if (src < 0) src = res;
      flg = {(src == 0), (src >= 128), c, v};
   endfunction

   // Issue one op from IDLE, scramble the inputs after accept, wait for the result
   // (bounded), read it, then retire it.
   task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] res, output logic [7:0] hi,
                         output logic [3:0] flg, output int lat);
      @(negedge clk);
      opcode = op; AC = a; R = b; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0; opcode = 4'($urandom); AC = 8'($urandom); R = 8'($urandom);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      res = result; hi = result_hi; flg = flags;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; in_valid = 1'b1; opcode = 4'h0; AC = 8'hF0; R = 8'h20; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (result !== 8'h00) begin bad++; $display("FAIL reset_result got=%h want=00", result); end
      total++; if (result_hi !== 8'h00) begin bad++; $display("FAIL reset_result_hi got=%h want=00", result_hi); end
      total++; if (flags !== 4'h0) begin bad++; $display("FAIL reset_flags got=%b want=0000", flags); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      in_valid = 1'b0;
      reset_n  = 1'b1;
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_out_valid got=%b want=0", out_valid); end
   endtask

   task automatic test_directed;
      logic [3:0] ops [5]  = '{4'h0, 4'h1, 4'hE, 4'hC, 4'hA};
      logic [7:0] as  [5]  = '{8'hF0, 8'h80, 8'h05, 8'h01, 8'h81};
      logic [7:0] bs  [5]  = '{8'h20, 8'h01, 8'h07, 8'h00, 8'h00};
      logic [7:0] ers [5]  = '{8'h10, 8'h7F, 8'h05, 8'h80, 8'hC0};
      logic [3:0] efl [5]  = '{4'b0010, 4'b0001, 4'b0110, 4'b0110, 4'b0110};
      logic [7:0] res, hi;
      logic [3:0] flg;
      int         lat;
      for (int i = 0; i < 5; i++) begin
         run_op(ops[i], as[i], bs[i], res, hi, flg, lat);
         total++; if (res !== ers[i]) begin bad++; $display("FAIL dir%0d_result got=%h want=%h", i, res, ers[i]); end
         total++; if (flg !== efl[i]) begin bad++; $display("FAIL dir%0d_flags got=%b want=%b", i, flg, efl[i]); end
         total++; if (hi !== 8'h00) begin bad++; $display("FAIL dir%0d_result_hi got=%h want=00", i, hi); end
         total++; if (lat !== 1) begin bad++; $display("FAIL dir%0d_latency got=%0d want=1", i, lat); end
      end
   endtask

   task automatic test_random;
      logic [3:0] op, eflg, flg;
      logic [7:0] a, b, res, hi;
      int         eres, ehi, elat, lat;
      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = 8'($urandom);
         b  = 8'($urandom);
         if (i % 10 == 0) b = a;  // exercise the zero / equal cases
         model_op(op, int'(a), int'(b), eres, ehi, eflg, elat);
         run_op(op, a, b, res, hi, flg, lat);
         total++; if (res !== 8'(eres)) begin bad++; $display("FAIL rnd%0d_result op=%h a=%h b=%h got=%h want=%h", i, op, a, b, res, 8'(eres)); end
         total++; if (hi !== 8'(ehi)) begin bad++; $display("FAIL rnd%0d_result_hi op=%h got=%h want=%h", i, op, hi, 8'(ehi)); end
         total++; if (flg !== eflg) begin bad++; $display("FAIL rnd%0d_flags op=%h a=%h b=%h got=%b want=%b", i, op, a, b, flg, eflg); end
         total++; if (lat !== elat) begin bad++; $display("FAIL rnd%0d_latency op=%h got=%0d want=%0d", i, op, lat, elat); end
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] xa [4];
      logic [7:0] xb [4];
      int         eres, ehi, elat;
      logic [3:0] eflg;
      model_op(4'h0, 'h3C, 'h55, eres, ehi, eflg, elat);
      @(negedge clk);
      opcode = 4'h0; AC = 8'h3C; R = 8'h55; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      // Competing request while back-pressured must be ignored.
      opcode = 4'h6; AC = 8'hAA; R = 8'h0F;
      for (int i = 0; i < 5; i++) begin
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold%0d_out_valid got=%b want=1", i, out_valid); end
         total++; if (result !== 8'(eres)) begin bad++; $display("FAIL hold%0d_result got=%h want=%h", i, result, 8'(eres)); end
         total++; if (flags !== eflg) begin bad++; $display("FAIL hold%0d_flags got=%b want=%b", i, flags, eflg); end
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold%0d_in_ready got=%b want=0", i, in_ready); end
         @(negedge clk);
      end
      for (int i = 0; i < 4; i++) begin
         xa[i] = 8'($urandom);
         xb[i] = 8'($urandom);
      end
      for (int i = 0; i < 4; i++) begin
         opcode = 4'h6; AC = xa[i]; R = xb[i]; in_valid = 1'b1; out_ready = 1'b1;
         #1;
         total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream%0d_in_ready got=%b want=1", i, in_ready); end
         @(negedge clk);
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream%0d_out_valid got=%b want=1", i, out_valid); end
         total++; if (result !== (xa[i] ^ xb[i])) begin bad++; $display("FAIL stream%0d_result got=%h want=%h", i, result, xa[i] ^ xb[i]); end
      end
      in_valid = 1'b0;
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain_out_valid got=%b want=0", out_valid); end
      out_ready = 1'b0;
   endtask

   task automatic test_mul;
      logic [7:0] res, hi;
      logic [3:0] flg;
      int         lat;
`ifdef ALU_SEQ_MUL_EN
      int         seen;
      run_op(4'hD, 8'hFF, 8'hFF, res, hi, flg, lat);
      total++; if ({hi, res} !== 16'hFE01) begin bad++; $display("FAIL mul_product got=%h want=fe01", {hi, res}); end
      total++; if (flg !== 4'b0011) begin bad++; $display("FAIL mul_flags got=%b want=0011", flg); end
      total++; if (lat !== 9) begin bad++; $display("FAIL mul_latency got=%0d want=9", lat); end
      @(negedge clk);
      opcode = 4'hD; AC = 8'hFF; R = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mul_busy_in_ready got=%b want=0", in_ready); end
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mul_abort_out_valid got=%b want=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mul_abort_in_ready got=%b want=1", in_ready); end
      @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen++;
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL mul_abort_no_result got=%0d want=0", seen); end
      out_ready = 1'b0;
`else
      run_op(4'hD, 8'hFF, 8'hFF, res, hi, flg, lat);
      total++; if (res !== 8'hFF) begin bad++; $display("FAIL nomul_result got=%h want=ff", res); end
      total++; if (hi !== 8'h00) begin bad++; $display("FAIL nomul_result_hi got=%h want=00", hi); end
      total++; if (flg !== 4'b0100) begin bad++; $display("FAIL nomul_flags got=%b want=0100", flg); end
      total++; if (lat !== 1) begin bad++; $display("FAIL nomul_latency got=%0d want=1", lat); end
`endif
   endtask

   initial begin
      test_reset;
      test_directed;
      test_random;
      test_back_to_back;
      test_mul;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
